// File: rtl/uop_sequencer_if.sv
// ---------------------------------------------------------------------------
// uop_sequencer_if
// Bundles every non-clock signal between the microcode sequencer and its
// environment (start/finish handshake, microcode ROM port, datapath port).
//
//   ena       start pulse, only looked at while the sequencer is idle
//   rdy       high when idle or the program has finished
//   uop_addr  microcode ROM address (6 bits)
//   uop_data  ROM word, valid one cycle after uop_addr changes
//   op_valid  one-cycle issue strobe to the datapath
//   op_opcode / op_src1 / op_src2 / op_dst  issued fields, stable until next issue
//   op_done   datapath completion pulse
//   cmp_eq    compare result, valid together with op_done for a CMP
//
// Handshake: the sequencer raises op_valid for exactly one cycle per issued
// microinstruction and then waits, with no timeout, for a single-cycle
// op_done; op_done at any other time carries no meaning and is ignored.
//
// Modports: master = sequencer side, slave = environment (ROM + datapath).
// ---------------------------------------------------------------------------
interface uop_sequencer_if;
    logic        ena;
    logic        rdy;
    logic [5:0]  uop_addr;
    logic [19:0] uop_data;
    logic        op_valid;
    logic [3:0]  op_opcode;
    logic [4:0]  op_src1;
    logic [4:0]  op_src2;
    logic [3:0]  op_dst;
    logic        op_done;
    logic        cmp_eq;

    modport master (
        input  ena, uop_data, op_done, cmp_eq,
        output rdy, uop_addr, op_valid, op_opcode, op_src1, op_src2, op_dst
    );

    modport slave (
        output ena, uop_data, op_done, cmp_eq,
        input  rdy, uop_addr, op_valid, op_opcode, op_src1, op_src2, op_dst
    );
endinterface

// File: rtl/uop_sequencer.sv
// ---------------------------------------------------------------------------
// uop_sequencer
// Steps through a 64-word microcode ROM, conditionally issuing each word to
// a datapath and waiting for its completion. A word with opcode RDY (or the
// completion/skip of the word at address 63) ends the program.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      uop_sequencer_if.master (handshake, ROM port, datapath port)
//   state_o  current FSM state for observation (IDLE=0 FETCH=1 DECODE=2
//            ISSUE=3 WAIT=4)
//
// ROM word: opcode[19:16] src1[15:11] src2[10:6] dst[5:2] exec[1:0]
// exec: 00 always, 01 if flag_eq, 10 if !flag_eq, 11 never.
// ---------------------------------------------------------------------------
module uop_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    uop_sequencer_if.master        bus,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_RDY   = 4'b0000;
    localparam logic [3:0] OP_CMP   = 4'b0001;
    localparam logic [5:0] LAST_ADDR = 6'd63;

    state_t      state_q, state_d;
    logic [5:0]  addr_q,  addr_d;
    logic        rdy_q,   rdy_d;
    logic        flag_q,  flag_d;
    logic [3:0]  opc_q,   opc_d;
    logic [4:0]  src1_q,  src1_d;
    logic [4:0]  src2_q,  src2_d;
    logic [3:0]  dst_q,   dst_d;

    // ROM word fields
    logic [3:0]  w_opc;
    logic [4:0]  w_src1;
    logic [4:0]  w_src2;
    logic [3:0]  w_dst;
    logic [1:0]  w_exec;
    logic        exec_ok;

    assign w_opc  = bus.uop_data[19:16];
    assign w_src1 = bus.uop_data[15:11];
    assign w_src2 = bus.uop_data[10:6];
    assign w_dst  = bus.uop_data[5:2];
    assign w_exec = bus.uop_data[1:0];

    always_comb begin
        exec_ok = 1'b0;
        case (w_exec)
            2'b00:   exec_ok = 1'b1;
            2'b01:   exec_ok = flag_q;
            2'b10:   exec_ok = ~flag_q;
            default: exec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 6'd0;
            rdy_q   <= 1'b1;
            flag_q  <= 1'b0;
            opc_q   <= 4'd0;
            src1_q  <= 5'd0;
            src2_q  <= 5'd0;
            dst_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdy_q   <= rdy_d;
            flag_q  <= flag_d;
            opc_q   <= opc_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdy_d   = rdy_q;
        flag_d  = flag_q;
        opc_d   = opc_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dst_d   = dst_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ena) begin
                    addr_d  = 6'd0;
                    rdy_d   = 1'b0;
                    flag_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end

            // One dead cycle so the synchronous ROM output matches addr_q.
            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                if (w_opc == OP_RDY) begin
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (!exec_ok) begin
                    // Skipped word; the last ROM word ends the program
                    // instead of wrapping back to address 0.
                    if (addr_q == LAST_ADDR) begin
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    opc_d   = w_opc;
                    src1_d  = w_src1;
                    src2_d  = w_src2;
                    dst_d   = w_dst;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: state_d = S_WAIT;

            S_WAIT: begin
                if (bus.op_done) begin
                    // opc_q still holds the issued opcode here.
                    if (opc_q == OP_CMP) begin
                        flag_d = bus.cmp_eq;
                    end
                    if (addr_q == LAST_ADDR) begin
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rdy       = rdy_q;
    assign bus.uop_addr  = addr_q;
    assign bus.op_valid  = (state_q == S_ISSUE);
    assign bus.op_opcode = opc_q;
    assign bus.op_src1   = src1_q;
    assign bus.op_src2   = src2_q;
    assign bus.op_dst    = dst_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_uop_sequencer.sv
module tb_uop_sequencer;

    localparam logic [3:0] RDY = 4'h0;
    localparam logic [3:0] CMP = 4'h1;
    localparam logic [3:0] MOV = 4'h2;
    localparam logic [3:0] ADD = 4'h3;
    localparam logic [3:0] SUB = 4'h4;
    localparam logic [3:0] MUL = 4'h5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    uop_sequencer_if u_if ();
    logic [2:0] state_o;

    uop_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (u_if),
        .state_o (state_o)
    );

    // ---------------- ROM model and datapath responder ----------------
    logic [19:0] rom [64];
    int          resp_delay;
    logic        resp_eq;
    logic        resp_done;
    logic        inj_done;

    always @(posedge clk) u_if.uop_data <= rom[u_if.uop_addr];

    assign u_if.op_done = resp_done | inj_done;
    assign u_if.cmp_eq  = resp_eq;

    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.op_valid === 1'b1) begin
                repeat (resp_delay) @(posedge clk);
                #1 resp_done = 1'b1;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    int n_checks;
    int n_fail;
    int n_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issue strobe must match the next expected {addr, op, s1, s2, dst}.
    always @(negedge clk) begin
        if (u_if.op_valid === 1'b1) begin
            n_issue++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got addr %0d op %0h expected no issue", u_if.uop_addr, u_if.op_opcode);
            end else begin
                check("issue", {8'd0, u_if.uop_addr, u_if.op_opcode, u_if.op_src1, u_if.op_src2, u_if.op_dst},
                      {8'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [19:0] mk(input logic [3:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [3:0] d, input logic [1:0] ex);
        return {op, s1, s2, d, ex};
    endfunction

    function automatic logic [23:0] ex_issue(input logic [5:0] a, input logic [3:0] op,
                                             input logic [4:0] s1, input logic [4:0] s2, input logic [3:0] d);
        return {a, op, s1, s2, d};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 20'd0;
    endtask

    // Pulses ena for one edge, returns cycles from that edge until rdy is seen high.
    task automatic run_prog(input int max_cyc, output int cyc);
        logic done;
        @(posedge clk);
        #1 u_if.ena = 1'b1;
        @(posedge clk);
        #1 u_if.ena = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
            #1 done = u_if.rdy;
        end
        check("run_finished", {31'd0, done}, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    int cyc;
    int wcyc;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        n_issue    = 0;
        resp_delay = 2;
        resp_eq    = 1'b0;
        inj_done   = 1'b0;
        u_if.ena   = 1'b0;
        clear_rom();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", {29'd0, state_o}, 32'd0);
        check("reset_rdy", {31'd0, u_if.rdy}, 32'd1);
        check("reset_addr", {26'd0, u_if.uop_addr}, 32'd0);
        check("reset_valid", {31'd0, u_if.op_valid}, 32'd0);
        check("reset_fields", {14'd0, u_if.op_opcode, u_if.op_src1, u_if.op_src2, u_if.op_dst}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Test 1: MOV, MUL, RDY with op_done two cycles after each issue.
        clear_rom();
        rom[0] = mk(MOV, 5'd3, 5'd7, 4'd1, 2'b00);
        rom[1] = mk(MUL, 5'd10, 5'd20, 4'd5, 2'b00);
        resp_delay = 2;
        exp_q.push_back(ex_issue(6'd0, MOV, 5'd3, 5'd7, 4'd1));
        exp_q.push_back(ex_issue(6'd1, MUL, 5'd10, 5'd20, 4'd5));
        run_prog(100, cyc);
        check("t1_cycles", cyc, 32'd12);
        check("t1_end_addr", {26'd0, u_if.uop_addr}, 32'd2);
        check("t1_fields_held", {14'd0, u_if.op_opcode, u_if.op_src1, u_if.op_src2, u_if.op_dst},
              {14'd0, MUL, 5'd10, 5'd20, 4'd5});

        // Test 2: CMP then conditional MOV, flag set on one run and clear on the next.
        clear_rom();
        rom[0] = mk(CMP, 5'd1, 5'd2, 4'd0, 2'b00);
        rom[1] = mk(MOV, 5'd4, 5'd5, 4'd6, 2'b01);
        resp_delay = 1;
        resp_eq = 1'b1;
        exp_q.push_back(ex_issue(6'd0, CMP, 5'd1, 5'd2, 4'd0));
        exp_q.push_back(ex_issue(6'd1, MOV, 5'd4, 5'd5, 4'd6));
        run_prog(100, cyc);
        check("t2a_cycles", cyc, 32'd10);
        resp_eq = 1'b0;
        exp_q.push_back(ex_issue(6'd0, CMP, 5'd1, 5'd2, 4'd0));
        run_prog(100, cyc);
        check("t2b_cycles", cyc, 32'd8);
        check("t2b_end_addr", {26'd0, u_if.uop_addr}, 32'd2);

        // Test 3: flag_eq=1, then exec=11 and exec=10 words are both skipped.
        clear_rom();
        rom[0] = mk(CMP, 5'd9, 5'd9, 4'd2, 2'b00);
        rom[1] = mk(ADD, 5'd1, 5'd1, 4'd1, 2'b11);
        rom[2] = mk(SUB, 5'd2, 5'd2, 4'd2, 2'b10);
        resp_delay = 1;
        resp_eq = 1'b1;
        exp_q.push_back(ex_issue(6'd0, CMP, 5'd9, 5'd9, 4'd2));
        run_prog(100, cyc);
        check("t3_cycles", cyc, 32'd10);
        check("t3_end_addr", {26'd0, u_if.uop_addr}, 32'd3);

        // Test 4: ena pulsed during WAIT, then op_done pulsed during IDLE.
        clear_rom();
        rom[0] = mk(MOV, 5'd17, 5'd30, 4'd15, 2'b00);
        resp_delay = 6;
        exp_q.push_back(ex_issue(6'd0, MOV, 5'd17, 5'd30, 4'd15));
        fork
            run_prog(100, cyc);
            begin
                repeat (6) @(posedge clk);
                #1 u_if.ena = 1'b1;
                @(posedge clk);
                #1 u_if.ena = 1'b0;
                check("t4_wait_ignores_ena", {29'd0, state_o}, 32'd4);
                check("t4_rdy_low_in_wait", {31'd0, u_if.rdy}, 32'd0);
            end
        join
        check("t4_cycles", cyc, 32'd11);
        @(posedge clk);
        #1 inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        check("t4_idle_ignores_done", {29'd0, state_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_idle_rdy", {31'd0, u_if.rdy}, 32'd1);
        check("t4_idle_addr", {26'd0, u_if.uop_addr}, 32'd1);

        // Test 5: asynchronous reset while waiting on the datapath.
        clear_rom();
        rom[0] = mk(MOV, 5'd3, 5'd7, 4'd1, 2'b00);
        rom[1] = mk(MUL, 5'd10, 5'd20, 4'd5, 2'b00);
        resp_delay = 20;
        exp_q.push_back(ex_issue(6'd0, MOV, 5'd3, 5'd7, 4'd1));
        exp_q.push_back(ex_issue(6'd1, MUL, 5'd10, 5'd20, 4'd5));
        @(posedge clk);
        #1 u_if.ena = 1'b1;
        @(posedge clk);
        #1 u_if.ena = 1'b0;
        wcyc = 0;
        while (state_o !== 3'd4 && wcyc < 50) begin
            @(negedge clk);
            wcyc++;
        end
        check("t5_reached_wait", {29'd0, state_o}, 32'd4);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_async_state", {29'd0, state_o}, 32'd0);
        check("t5_async_rdy", {31'd0, u_if.rdy}, 32'd1);
        check("t5_async_addr", {26'd0, u_if.uop_addr}, 32'd0);
        check("t5_async_valid", {31'd0, u_if.op_valid}, 32'd0);
        check("t5_async_fields", {14'd0, u_if.op_opcode, u_if.op_src1, u_if.op_src2, u_if.op_dst}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t5_idle_after_release", {29'd0, state_o}, 32'd0);
        resp_delay = 2;
        exp_q.push_back(ex_issue(6'd0, MOV, 5'd3, 5'd7, 4'd1));
        exp_q.push_back(ex_issue(6'd1, MUL, 5'd10, 5'd20, 4'd5));
        run_prog(100, cyc);
        check("t5_restart_cycles", cyc, 32'd12);

        // Test 6: no RDY word anywhere, program ends after address 63.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = i[5:0];
            rom[i] = mk(MOV, a[4:0], ~a[4:0], a[3:0], 2'b00);
            exp_q.push_back(ex_issue(a, MOV, a[4:0], ~a[4:0], a[3:0]));
        end
        resp_delay = 1;
        n_issue = 0;
        run_prog(400, cyc);
        check("t6_cycles", cyc, 32'd256);
        check("t6_end_addr", {26'd0, u_if.uop_addr}, 32'd63);
        repeat (10) @(posedge clk);
        #1;
        check("t6_issue_count", n_issue, 32'd64);
        check("t6_still_idle", {29'd0, state_o}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uop_sequencer.md
UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 ena  input  1  start pulse; sampled only in IDLE.
REQ-004 rdy  output  1  high when idle or the program has finished; low while running.
REQ-005 uop_addr  output  6  microcode ROM address.
REQ-006 uop_data  input  20  ROM word, valid one cycle after uop_addr changes (synchronous ROM).
REQ-007 op_valid  output  1  one-cycle issue strobe to datapath.
REQ-008 op_opcode  output  4  issued opcode.
REQ-009 op_src1 / op_src2  output  5 each  issued operand selects.
REQ-010 op_dst  output  4  issued destination select.
REQ-011 op_done  input  1  datapath completion pulse.
REQ-012 cmp_eq  input  1  datapath compare result, valid when op_done is high for a CMP.

Function
REQ-013 ROM word fields: opcode [19:16], src1 [15:11], src2 [10:6], dst [5:2], exec [1:0].
REQ-014 Opcodes: RDY=0000, CMP=0001, MOV=0010, ADD=0011, SUB=0100, MUL=0101; all non-RDY opcodes are forwarded to the datapath unchanged.
REQ-015 Exec codes: 00 always; 01 if flag_eq=1; 10 if flag_eq=0; 11 never (skip).
REQ-016 flag_eq: internal 1-bit register, loaded from cmp_eq on op_done in WAIT when the issued opcode is CMP; otherwise held.
REQ-017 States: IDLE, FETCH, DECODE, ISSUE, WAIT.
REQ-018 IDLE: ena=1 -> uop_addr<=0, rdy<=0, flag_eq<=0, go to FETCH; ena=0 -> stay in IDLE.
REQ-019 FETCH: unconditional transition to DECODE (covers ROM latency).
REQ-020 DECODE, opcode RDY -> rdy<=1, go to IDLE; uop_addr holds.
REQ-021 DECODE, exec condition false -> skip: uop_addr<=uop_addr+1, go to FETCH.
REQ-022 DECODE, exec condition true -> latch op_* fields from uop_data, go to ISSUE.
REQ-023 ISSUE: op_valid=1 for exactly this cycle, go to WAIT; op_* fields stay stable until the next issue.
REQ-024 WAIT: op_done=1 -> uop_addr<=uop_addr+1, go to FETCH; op_done=0 -> stay in WAIT (no timeout).
REQ-025 Timing: a skipped microinstruction costs 2 cycles; an executed one costs 3 cycles plus the datapath wait (minimum 1 cycle in WAIT).
REQ-026 End of ROM: a non-RDY word at address 63, once completed or skipped, ends the program (rdy<=1, IDLE, uop_addr stays 63); no wrap to 0.
REQ-027 ena while running (rdy=0) is ignored; op_done outside WAIT is ignored.
REQ-028 op_done and ena in the same cycle: each is evaluated only in its own state; no interaction.

Reset
REQ-029 On rst_n low, immediately and asynchronously: state=IDLE, rdy=1, uop_addr=0, op_valid=0, op_opcode/op_src1/op_src2/op_dst=0, flag_eq=0.
REQ-030 Reset mid-program aborts the program with no further op_valid; after release, the block waits for a fresh ena.

Verification
REQ-031 Program {MOV always; MUL always; RDY}, op_done 2 cycles after each op_valid -> exactly 2 op_valid pulses with correct fields, uop_addr sequence 0,1,2; rdy rises 12 cycles after the ena edge.
REQ-032 Program {CMP; MOV exec=01; RDY} with cmp_eq=1 then cmp_eq=0 on separate runs -> MOV issued on the first run, skipped on the second (one op_valid, rdy 2 cycles earlier).
REQ-033 Exec=11 word and exec=10 word with flag_eq=1 -> both skipped, no op_valid, uop_addr still advances.
REQ-034 ena pulsed while in WAIT, and op_done pulsed while in IDLE -> no state change, no extra op_valid.
REQ-035 rst_n asserted during WAIT -> outputs take reset values without a clock edge; ena after release restarts at uop_addr=0.
REQ-036 ROM with no RDY word (64 MOV always) -> 64 op_valid pulses, then rdy=1 with uop_addr=63; no 65th issue.
